// File: rtl/pool_ctrl_pkg.sv
// Shared types for the 2x2 pooling sequencer: FSM states, error causes and a
// width helper for counters whose modulus may be 1.
package pool_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StErr
    } state_e;

    typedef enum logic [2:0] {
        EOP_POS,
        EOF_POS,
        SOP_POS,
        SOF_MID,
        OVF,
        UDF
    } err_cause_e;

    localparam int unsigned NumErrCauses = 6;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrap_cnt.sv
// Modulus counter with enable, synchronous clear and a carry-style wrap flag.
// nxt_o exposes the value the counter takes on the coming edge.
module wrap_cnt
    import pool_ctrl_pkg::*;
#(
    parameter int unsigned Modulus = 4,
    parameter int unsigned Width   = cnt_width(Modulus)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o,
    output logic [Width-1:0] nxt_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] Last = Width'(Modulus - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap_o = en_i && !clr_i && (cnt_q == Last);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nxt_o = cnt_d;

endmodule

// File: rtl/pool_seq_ctrl.sv
// Sequencer for 2x2 pooling: tracks beat position in a frame, emits line-FIFO
// write/read strobes, pooled-output framing and protocol-error pulses.
module pool_seq_ctrl
    import pool_ctrl_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM = 3,
    parameter int unsigned STRING_LEN  = 4,
    parameter int unsigned LINE_NUM    = 4
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        sop_i,
    input  logic                                        eop_i,
    input  logic                                        sof_i,
    input  logic                                        eof_i,
    input  logic                                        valid_i,
    output logic [cnt_width(CHANNEL_NUM)-1:0]           chan_o,
    output logic [cnt_width(STRING_LEN)-1:0]            col_o,
    output logic [cnt_width(LINE_NUM)-1:0]              row_o,
    output logic                                        fifo_wr_o,
    output logic                                        fifo_rd_o,
    output logic                                        out_valid_o,
    output logic                                        sop_o,
    output logic                                        eop_o,
    output logic                                        sof_o,
    output logic                                        eof_o,
    output logic [$clog2(CHANNEL_NUM*STRING_LEN/2):0]   fill_o,
    output logic                                        err_o
);

    localparam int unsigned ChanW   = cnt_width(CHANNEL_NUM);
    localparam int unsigned ColW    = cnt_width(STRING_LEN);
    localparam int unsigned RowW    = cnt_width(LINE_NUM);
    localparam int unsigned FillMax = CHANNEL_NUM * STRING_LEN / 2;
    localparam int unsigned FillW   = $clog2(FillMax) + 1;

    localparam logic [ChanW-1:0] ChanLast = ChanW'(CHANNEL_NUM - 1);
    localparam logic [ColW-1:0]  ColLast  = ColW'(STRING_LEN - 1);
    localparam logic [RowW-1:0]  RowLast  = RowW'(LINE_NUM - 1);
    localparam logic [ColW-1:0]  ColOne   = ColW'(1);
    localparam logic [RowW-1:0]  RowOne   = RowW'(1);
    localparam logic [FillW-1:0] FillFull = FillW'(FillMax);

    state_e state_q, state_d;

    logic [ChanW-1:0] chan_nxt;
    logic [ColW-1:0]  col_nxt;
    logic [RowW-1:0]  row_nxt;
    logic             chan_wrap, col_wrap, row_wrap;

    logic sof_beat, adv, beat, line_end, is_last, frame_err, emit;
    logic [NumErrCauses-1:0] err_cause;

    logic wr_d, rd_d, ov_d, sop_d, eop_d, sof_d, eof_d, err_d;
    logic wr_q, rd_q, ov_q, sop_q, eop_q, sof_q, eof_q, err_q;
    logic [FillW-1:0] fill_base, fill_d, fill_q;

    // Any sof beat resynchronises to position 0; other beats advance only in ACTIVE.
    assign sof_beat = valid_i && sof_i;
    assign adv      = valid_i && !sof_i && (state_q == StActive);
    assign beat     = sof_beat || adv;

    wrap_cnt #(
        .Modulus (CHANNEL_NUM),
        .Width   (ChanW)
    ) u_chan_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (adv),
        .clr_i  (sof_beat),
        .cnt_o  (chan_o),
        .nxt_o  (chan_nxt),
        .wrap_o (chan_wrap)
    );

    wrap_cnt #(
        .Modulus (STRING_LEN),
        .Width   (ColW)
    ) u_col_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (chan_wrap),
        .clr_i  (sof_beat),
        .cnt_o  (col_o),
        .nxt_o  (col_nxt),
        .wrap_o (col_wrap)
    );

    wrap_cnt #(
        .Modulus (LINE_NUM),
        .Width   (RowW)
    ) u_row_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (col_wrap),
        .clr_i  (sof_beat),
        .cnt_o  (row_o),
        .nxt_o  (row_nxt),
        .wrap_o (row_wrap)
    );

    always_comb begin
        line_end  = (chan_nxt == ChanLast) && (col_nxt == ColLast);
        is_last   = line_end && (row_nxt == RowLast);

        err_cause          = '0;
        err_cause[EOP_POS] = beat && eop_i && !line_end;
        err_cause[EOF_POS] = beat && eof_i && !is_last;
        err_cause[SOP_POS] = beat && sop_i && !((chan_nxt == '0) && (col_nxt == '0));
        err_cause[SOF_MID] = sof_beat && (state_q == StActive);

        // A misplaced eop/eof rejects the beat: no strobes, FSM parks in ERR.
        frame_err = err_cause[EOP_POS] || err_cause[EOF_POS];
        emit      = beat && !frame_err;

        wr_d  = emit && !row_nxt[0] && col_nxt[0];
        rd_d  = emit && row_nxt[0] && !col_nxt[0];
        ov_d  = emit && row_nxt[0] && col_nxt[0];
        sop_d = ov_d && (col_nxt == ColOne) && (chan_nxt == '0);
        eop_d = ov_d && line_end;
        sof_d = sop_d && (row_nxt == RowOne);
        eof_d = eop_d && (row_nxt == RowLast);

        fill_base      = sof_beat ? '0 : fill_q;
        fill_d         = fill_base;
        err_cause[OVF] = wr_d && !rd_d && (fill_base == FillFull);
        err_cause[UDF] = rd_d && !wr_d && (fill_base == '0);
        if (wr_d && !rd_d && !err_cause[OVF]) begin
            fill_d = fill_base + 1'b1;
        end else if (rd_d && !wr_d && !err_cause[UDF]) begin
            fill_d = fill_base - 1'b1;
        end

        err_d = |err_cause;
    end

    always_comb begin
        state_d = state_q;
        if (beat) begin
            if (frame_err) begin
                state_d = StErr;
            end else if (is_last || row_wrap) begin
                state_d = StIdle;
            end else begin
                state_d = StActive;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ov_q    <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ov_q    <= ov_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
            fill_q  <= fill_d;
        end
    end

    assign fifo_wr_o   = wr_q;
    assign fifo_rd_o   = rd_q;
    assign out_valid_o = ov_q;
    assign sop_o       = sop_q;
    assign eop_o       = eop_q;
    assign sof_o       = sof_q;
    assign eof_o       = eof_q;
    assign err_o       = err_q;
    assign fill_o      = fill_q;

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Self-checking bench for pool_seq_ctrl (3 channels, 4x4 pixels) against a
// beat-index reference model.
module tb_pool_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sop_i = 1'b0, eop_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0, valid_i = 1'b0;
    logic [1:0] chan_o, col_o, row_o;
    logic       fifo_wr_o, fifo_rd_o, out_valid_o, sop_o, eop_o, sof_o, eof_o, err_o;
    logic [3:0] fill_o;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: mode 0 idle, 1 in frame, 2 error-parked.
    int m_mode, m_idx, m_fill, m_ch, m_co, m_ro;
    bit m_wr, m_rd, m_ov, m_sop, m_eop, m_sof, m_eof, m_err;

    pool_seq_ctrl #(
        .CHANNEL_NUM (3),
        .STRING_LEN  (4),
        .LINE_NUM    (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sop_i       (sop_i),
        .eop_i       (eop_i),
        .sof_i       (sof_i),
        .eof_i       (eof_i),
        .valid_i     (valid_i),
        .chan_o      (chan_o),
        .col_o       (col_o),
        .row_o       (row_o),
        .fifo_wr_o   (fifo_wr_o),
        .fifo_rd_o   (fifo_rd_o),
        .out_valid_o (out_valid_o),
        .sop_o       (sop_o),
        .eop_o       (eop_o),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
        .fill_o      (fill_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] dut_vec();
        return {chan_o, col_o, row_o, fifo_wr_o, fifo_rd_o, out_valid_o,
                sop_o, eop_o, sof_o, eof_o, fill_o, err_o};
    endfunction

    function automatic logic [17:0] exp_vec();
        return {2'(m_ch), 2'(m_co), 2'(m_ro), m_wr, m_rd, m_ov,
                m_sop, m_eop, m_sof, m_eof, 4'(m_fill), m_err};
    endfunction

    // Legal framing flags {sof, sop, eop, eof} for beat index b of a 48-beat frame.
    function automatic logic [3:0] flags_for(input int b);
        return {b == 0, (b % 12) == 0, (b % 12) == 11, b == 47};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_fill = 0;
        m_ch = 0; m_co = 0; m_ro = 0;
        {m_wr, m_rd, m_ov, m_sop, m_eop, m_sof, m_eof, m_err} = '0;
    endtask

    // Drive one cycle, advance the model, and land #1 after the rising edge.
    task automatic drive_beat(input bit v, input logic [3:0] f);
        bit beat, lastb, lend;
        valid_i = v;
        {sof_i, sop_i, eop_i, eof_i} = f;
        beat = 0;
        {m_wr, m_rd, m_ov, m_sop, m_eop, m_sof, m_eof, m_err} = '0;
        if (v && f[3]) begin
            if (m_mode == 1) m_err = 1;
            m_idx = 0; m_fill = 0; beat = 1;
        end else if (v && m_mode == 1) begin
            m_idx++; beat = 1;
        end
        if (beat) begin
            m_ch = m_idx % 3; m_co = (m_idx / 3) % 4; m_ro = m_idx / 12;
            lastb = (m_idx == 47);
            lend  = (m_co == 3) && (m_ch == 2);
            if (f[2] && !(m_ch == 0 && m_co == 0)) m_err = 1;
            if ((f[1] && !lend) || (f[0] && !lastb)) begin
                m_err = 1; m_mode = 2;
            end else begin
                m_wr  = (m_ro % 2 == 0) && (m_co % 2 == 1);
                m_rd  = (m_ro % 2 == 1) && (m_co % 2 == 0);
                m_ov  = (m_ro % 2 == 1) && (m_co % 2 == 1);
                m_sop = m_ov && m_co == 1 && m_ch == 0;
                m_eop = m_ov && lend;
                m_sof = m_sop && m_ro == 1;
                m_eof = m_eop && m_ro == 3;
                if (m_wr) begin if (m_fill == 6) m_err = 1; else m_fill++; end
                if (m_rd) begin if (m_fill == 0) m_err = 1; else m_fill--; end
                m_mode = lastb ? 0 : 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if (dut_vec() !== 18'h0) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", dut_vec(), 18'h0);
        end
        n_cmp++;
        reset_n = 1'b1;
        drive_beat(0, 4'b0000);
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec());
        end
        n_cmp++;
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 10; i++) begin
            drive_beat(1, {1'b0, 3'($urandom_range(0, 7))});
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_ignore cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
        if ({chan_o, col_o, row_o} !== 6'h0) begin
            n_fail++;
            $display("FAIL idle_counters: got %h want 0", {chan_o, col_o, row_o});
        end
        n_cmp++;
    endtask

    task automatic test_clean_frame(input bit gaps);
        int n_wr, n_rd, n_ov, n_sop, n_eop, n_sof, n_eof, peak;
        n_wr = 0; n_rd = 0; n_ov = 0; n_sop = 0; n_eop = 0; n_sof = 0; n_eof = 0; peak = 0;
        for (int b = 0; b < 48; b++) begin
            if (gaps && b > 0) begin
                repeat ($urandom_range(1, 3)) begin
                    drive_beat(0, 4'($urandom_range(0, 15)));
                    if (dut_vec() !== exp_vec()) begin
                        n_fail++;
                        $display("FAIL gap before beat %0d: got %h want %h",
                                 b, dut_vec(), exp_vec());
                    end
                    n_cmp++;
                end
            end
            drive_beat(1, flags_for(b));
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL frame(gaps=%0d) beat %0d: got %h want %h",
                         gaps, b, dut_vec(), exp_vec());
            end
            n_cmp++;
            n_wr += int'(fifo_wr_o); n_rd += int'(fifo_rd_o); n_ov += int'(out_valid_o);
            n_sop += int'(sop_o); n_eop += int'(eop_o); n_sof += int'(sof_o);
            n_eof += int'(eof_o);
            if (int'(fill_o) > peak) peak = int'(fill_o);
            if (b == 47 && eof_o !== 1'b1) begin
                n_fail++;
                $display("FAIL eof_on_47: got %b want 1", eof_o);
            end
            if (b == 47) n_cmp++;
        end
        if ({n_wr, n_rd, n_ov} !== {32'd12, 32'd12, 32'd12}) begin
            n_fail++;
            $display("FAIL strobe_counts: got wr=%0d rd=%0d ov=%0d want 12 each",
                     n_wr, n_rd, n_ov);
        end
        n_cmp++;
        if ({n_sop, n_eop, n_sof, n_eof} !== {32'd2, 32'd2, 32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL framing_counts: got sop=%0d eop=%0d sof=%0d eof=%0d want 2 2 1 1",
                     n_sop, n_eop, n_sof, n_eof);
        end
        n_cmp++;
        if (peak !== 6 || fill_o !== 4'd0) begin
            n_fail++;
            $display("FAIL fill_profile: got peak=%0d end=%0d want 6 0", peak, fill_o);
        end
        n_cmp++;
    endtask

    task automatic test_eop_error();
        for (int b = 0; b < 6; b++) begin
            drive_beat(1, flags_for(b) | ((b == 5) ? 4'b0010 : 4'b0000));
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL eop_err beat %0d: got %h want %h", b, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL eop_err_pulse: got %b want 1", err_o);
        end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            drive_beat(i != 0, 4'b0000);
            if (dut_vec() !== exp_vec() || err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL err_state cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
        test_clean_frame(0);
    endtask

    task automatic test_sof_mid();
        for (int b = 0; b < 21; b++) begin
            drive_beat(1, (b == 20) ? flags_for(0) : flags_for(b));
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL sof_mid beat %0d: got %h want %h", b, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
        if ({err_o, chan_o, col_o, row_o, fill_o} !== {1'b1, 6'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL sof_mid_resync: got err=%b pos=%h fill=%0d want err=1 pos=0 fill=0",
                     err_o, {chan_o, col_o, row_o}, fill_o);
        end
        n_cmp++;
        for (int b = 1; b < 48; b++) begin
            drive_beat(1, flags_for(b));
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL sof_mid_rest beat %0d: got %h want %h", b, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        logic [3:0] f;
        for (int i = 0; i < 400; i++) begin
            f = flags_for((m_mode == 1) ? m_idx + 1 : 0);
            if (m_mode != 1) f[3] = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 49) == 0) f[3] = 1'b1;
            if ($urandom_range(0, 19) == 0) f[$urandom_range(0, 2)] ^= 1'b1;
            drive_beat($urandom_range(0, 3) != 0, f);
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_async_reset();
        for (int b = 0; b < 31; b++) drive_beat(1, flags_for(b));
        valid_i = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        if (dut_vec() !== 18'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h want 0", dut_vec());
        end
        n_cmp++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int b = 31; b < 36; b++) begin
            drive_beat(1, flags_for(b));
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset beat %0d: got %h want %h", b, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
        test_clean_frame(0);
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_clean_frame(0);
        test_clean_frame(1);
        test_eop_error();
        test_sof_mid();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
